// File: rtl/mbfetch_luma4x4.sv
// Fetches one 4x4 luma block plus its intra-prediction neighbours (A..H, M, I..L)
// from a byte-wide frame memory with one-cycle read latency.
module mbfetch_luma4x4 #(
    parameter int FRAME_W = 176,
    parameter int FRAME_H = 144,
    parameter int ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [12:0]       blknumber,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [127:0]      mb,
    output logic [63:0]       top,
    output logic [39:0]       left,
    output logic              top_avail,
    output logic              left_avail,
    output logic [2:0]        dbg_state
);
    // Handshake: start is taken only while idle (busy low); busy stays high through
    // the done pulse, and results hold until the next accepted start.
    typedef enum logic [2:0] {
        S_IDLE, S_BLK, S_TOP, S_CORNER, S_LEFT, S_DRAIN, S_DONE
    } state_t;

    localparam logic [12:0] BW   = 13'(FRAME_W / 4);
    localparam int          NBLK = (FRAME_W / 4) * (FRAME_H / 4);

    state_t            state, state_n;
    logic [3:0]        idx, idx_n;
    logic [12:0]       bx, by;
    logic              bad;
    logic [ADDR_W-1:0] cur_addr, last_addr;
    logic              cap_v;
    logic [4:0]        cap_dst, dst_c;
    logic              accept, in_range, right_edge;
    int                x_c, y_c;

    assign accept     = (state == S_IDLE) && start;
    assign in_range   = int'(blknumber) < NBLK;
    assign right_edge = (bx == BW - 13'd1);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign dbg_state  = state;

    // Phase sequencing; skipped phases are jumped over so they cost no cycles.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = in_range ? S_BLK : S_DRAIN;
            S_BLK:    if (idx == 4'd15) state_n = (|by) ? S_TOP : (|bx) ? S_LEFT : S_DRAIN;
            S_TOP:    if (idx == (right_edge ? 4'd3 : 4'd7)) state_n = (|bx) ? S_CORNER : S_DRAIN;
            S_CORNER: state_n = S_LEFT;
            S_LEFT:   if (idx == 4'd3) state_n = S_DRAIN;
            S_DRAIN:  state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        idx_n = (state_n != state) ? 4'd0 : idx + 4'd1;
    end

    // Pixel coordinate and capture slot of the read issued this cycle.
    // Slots: 0..15 block, 16..23 A..H, 24 M, 25..28 I..L.
    always_comb begin
        x_c    = 4 * int'(bx) - 1;
        y_c    = 4 * int'(by) - 1;
        dst_c  = 5'd24;
        mem_rd = 1'b1;
        case (state)
            S_BLK: begin
                x_c   = 4 * int'(bx) + int'(idx[1:0]);
                y_c   = 4 * int'(by) + int'(idx[3:2]);
                dst_c = {1'b0, idx};
            end
            S_TOP: begin
                x_c   = 4 * int'(bx) + int'(idx);
                dst_c = 5'd16 + {1'b0, idx};
            end
            S_CORNER: ;
            S_LEFT: begin
                y_c   = 4 * int'(by) + int'(idx);
                dst_c = 5'd25 + {1'b0, idx};
            end
            default: mem_rd = 1'b0;
        endcase
        cur_addr = ADDR_W'(y_c * FRAME_W + x_c);
        mem_addr = mem_rd ? cur_addr : last_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            bx         <= 13'd0;
            by         <= 13'd0;
            bad        <= 1'b0;
            err        <= 1'b0;
            top_avail  <= 1'b0;
            left_avail <= 1'b0;
            mb         <= '0;
            top        <= '0;
            left       <= '0;
            last_addr  <= '0;
            cap_v      <= 1'b0;
            cap_dst    <= 5'd0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cap_v   <= mem_rd;
            cap_dst <= dst_c;
            if (mem_rd) last_addr <= cur_addr;
            if (accept) begin
                bx  <= blknumber % BW;
                by  <= blknumber / BW;
                bad <= !in_range;
                err <= 1'b0;
                // Defaults for neighbours that will not be read; an invalid request keeps old results.
                if (in_range) begin
                    top        <= {8{8'd128}};
                    left       <= {5{8'd128}};
                    top_avail  <= (blknumber >= BW);
                    left_avail <= ((blknumber % BW) != 13'd0);
                end
            end
            if (state == S_DRAIN && bad) err <= 1'b1;
            if (cap_v) begin
                if (cap_dst < 5'd16) begin
                    mb[8*int'(cap_dst) +: 8] <= mem_data;
                end else if (cap_dst < 5'd24) begin
                    top[8*(int'(cap_dst)-16) +: 8] <= mem_data;
                    // At the right frame edge E..H are never read and replicate D.
                    if (cap_dst == 5'd19 && right_edge) top[63:32] <= {4{mem_data}};
                end else begin
                    left[8*(int'(cap_dst)-24) +: 8] <= mem_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mbfetch_luma4x4.sv
// Randomized bench for mbfetch_luma4x4: a reference model derives the read order
// and results from block coordinates; a monitor checks reads and done responses.
module tb_mbfetch_luma4x4;
    localparam int FW = 176;
    localparam int FH = 144;
    localparam int AW = 15;
    localparam int BW = FW / 4;
    localparam int NB = BW * (FH / 4);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [12:0]   blknumber = 13'd0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          busy, done, err, top_avail, left_avail;
    logic [127:0]  mb;
    logic [63:0]   top;
    logic [39:0]   left;
    logic [2:0]    dbg_state;

    mbfetch_luma4x4 #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .blknumber(blknumber),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .err(err), .mb(mb), .top(top), .left(left),
        .top_avail(top_avail), .left_avail(left_avail), .dbg_state(dbg_state)
    );

    // clock / reset / memory
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [FW*FH];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    // scoreboard
    typedef struct {
        logic [127:0] mb;
        logic [63:0]  top;
        logic [39:0]  left;
        logic         err;
        logic         chk_avail;
        logic         ta;
        logic         la;
        int           done_cyc;
    } exp_t;

    logic [AW-1:0] addr_q [$];
    exp_t          res_q [$];
    logic [127:0]  last_mb = '0;
    logic [63:0]   last_top = '0;
    logic [39:0]   last_left = '0;
    logic          last_err = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    endtask

    // Reference model: expected read list and results straight from block coordinates.
    task automatic model_fetch(input int blk, input int c0, output int n);
        exp_t e;
        int bx, by, a;
        n = 0;
        if (blk >= NB) begin
            e.mb = last_mb; e.top = last_top; e.left = last_left;
            e.err = 1'b1; e.chk_avail = 1'b0; e.ta = 1'b0; e.la = 1'b0;
        end else begin
            bx = blk % BW;
            by = blk / BW;
            for (int i = 0; i < 16; i++) begin
                a = (4*by + i/4) * FW + 4*bx + i%4;
                addr_q.push_back(AW'(a)); e.mb[8*i +: 8] = mem[a]; n++;
            end
            e.top = {8{8'd128}};
            if (by > 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < 4 || bx < BW - 1) begin
                        a = (4*by - 1) * FW + 4*bx + k;
                        addr_q.push_back(AW'(a)); e.top[8*k +: 8] = mem[a]; n++;
                    end else begin
                        e.top[8*k +: 8] = e.top[31:24];
                    end
                end
            end
            e.left = {5{8'd128}};
            if (bx > 0 && by > 0) begin
                a = (4*by - 1) * FW + 4*bx - 1;
                addr_q.push_back(AW'(a)); e.left[7:0] = mem[a]; n++;
            end
            if (bx > 0) begin
                for (int r = 0; r < 4; r++) begin
                    a = (4*by + r) * FW + 4*bx - 1;
                    addr_q.push_back(AW'(a)); e.left[8*(r+1) +: 8] = mem[a]; n++;
                end
            end
            e.err = 1'b0; e.chk_avail = 1'b1; e.ta = (by > 0); e.la = (bx > 0);
            last_mb = e.mb; last_top = e.top; last_left = e.left;
        end
        last_err = e.err;
        e.done_cyc = c0 + n + 2;
        res_q.push_back(e);
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: actual addr %0d expected no read", mem_addr);
                end else begin
                    chk("mem_addr", 128'(mem_addr), 128'(addr_q.pop_front()));
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: actual done=1 expected 0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = res_q.pop_front();
                    chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    chk("mb", mb, e.mb);
                    chk("top", 128'(top), 128'(e.top));
                    chk("left", 128'(left), 128'(e.left));
                    chk("err", 128'(err), 128'(e.err));
                    chk("busy_at_done", 128'(busy), 128'(1));
                    if (e.chk_avail) begin
                        chk("top_avail", 128'(top_avail), 128'(e.ta));
                        chk("left_avail", 128'(left_avail), 128'(e.la));
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic wait_all(input int budget);
        int k;
        k = 0;
        while (res_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen_pending", 128'(res_q.size()), 128'(0));
        res_q.delete();
        @(posedge clk); #1;
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_err_hold", 128'(err), 128'(last_err));
        chk("reads_outstanding", 128'(addr_q.size()), 128'(0));
        addr_q.delete();
    endtask

    task automatic fetch(input int blk);
        int c0, n;
        @(negedge clk);
        start = 1'b1;
        blknumber = 13'(blk);
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc - 1;
        model_fetch(blk, c0, n);
        chk("busy_cycle1", 128'(busy), 128'(1));
        chk("err_cleared", 128'(err), 128'(0));
        wait_all(100);
    endtask

    task automatic fill_random();
        for (int i = 0; i < FW*FH; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int c0, n1, n2, b1, b2, blk;
        for (int i = 0; i < FW*FH; i++) mem[i] = 8'(i % 256);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_rd", 128'(mem_rd), 128'(0));
        chk("rst_addr", 128'(mem_addr), 128'(0));
        chk("rst_mb", mb, 128'(0));
        chk("rst_nb", 128'({top, left, top_avail, left_avail}), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // directed: corner block, interior, right edge, invalid, other edges
        fetch(0);
        fetch(45);
        fetch(87);
        fetch(1584);
        fetch(44);
        fetch(43);
        fetch(NB - 1);

        // reset in cycle 10 of a block-45 fetch
        @(negedge clk);
        start = 1'b1;
        blknumber = 13'd45;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc - 1;
        model_fetch(45, c0, n1);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_rd", 128'(mem_rd), 128'(0));
        chk("mid_rst_addr", 128'(mem_addr), 128'(0));
        chk("mid_rst_mb", mb, 128'(0));
        chk("mid_rst_nb", 128'({top, left, done, err, top_avail, left_avail}), 128'(0));
        addr_q.delete();
        res_q.delete();
        last_mb = '0; last_top = '0; last_left = '0; last_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        fetch(1600);
        fetch(45);

        // start held high: second fetch accepted the cycle after done
        fill_random();
        b1 = $urandom_range(0, NB - 1);
        b2 = $urandom_range(0, NB - 1);
        @(negedge clk);
        start = 1'b1;
        blknumber = 13'(b1);
        @(posedge clk); #1;
        c0 = cyc - 1;
        model_fetch(b1, c0, n1);
        blknumber = 13'(b2);
        model_fetch(b2, c0 + n1 + 3, n2);
        repeat (n1 + 3) @(posedge clk);
        #1 start = 1'b0;
        wait_all(200);

        // randomized blocks, occasionally out of range
        for (int t = 0; t < 12; t++) begin
            fill_random();
            if ($urandom_range(0, 5) == 0) blk = $urandom_range(NB, 8191);
            else blk = $urandom_range(0, NB - 1);
            fetch(blk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
